// File: rtl/xadc_drp_scheduler.sv
// XADC DRP read scheduler: on each end-of-conversion, read the next enabled slot round-robin.
// Latency: eoc -> den 1 cycle; drdy -> sample_valid 1 cycle; abort after TIMEOUT WAIT cycles.
// Backpressure: one eoc queued while busy; a further eoc is dropped and flagged on overrun.
module xadc_drp_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7*NUM_CH-1:0]   ch_addr,
  input  logic [NUM_CH-1:0]     ch_enable,
  input  logic                  eoc,
  output logic                  den,
  output logic [6:0]            daddr,
  output logic                  dwe,
  input  logic                  drdy,
  input  logic [15:0]           do_in,
  output logic [15:0]           sample_out,
  output logic [2:0]            sample_ch,
  output logic                  sample_valid,
  output logic                  timeout_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [2:0]    SLOT_TOP = 3'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t          state, state_n;
  logic [2:0]      grant, grant_n;
  logic [2:0]      last_slot, last_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            pending, pending_n;
  logic            den_n, sval_n, tmo_n, ovr_n;
  logic [6:0]      daddr_n;
  logic [15:0]     sout_n;
  logic [2:0]      sch_n;

  // Slot tables padded to the 8-slot maximum so a 3-bit slot index always fits.
  logic [7:0]      en_pad;
  logic [55:0]     addr_pad;
  logic [6:0]      addr_arr [8];
  logic [2:0]      rr_idx;
  logic [2:0]      rr_slot;
  logic            rr_found;

  assign en_pad   = 8'(ch_enable);
  assign addr_pad = 56'(ch_addr);
  assign dwe      = 1'b0;
  assign busy     = (state != IDLE);

  // Round-robin pick: first enabled slot after last_slot, ending on last_slot itself.
  always_comb begin
    for (int i = 0; i < 8; i++) addr_arr[i] = addr_pad[7*i +: 7];
    rr_idx   = last_slot;
    rr_slot  = last_slot;
    rr_found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      rr_idx = (rr_idx == SLOT_TOP) ? 3'd0 : rr_idx + 3'd1;
      if (!rr_found && en_pad[rr_idx]) begin
        rr_found = 1'b1;
        rr_slot  = rr_idx;
      end
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_n   = state;
    grant_n   = grant;
    last_n    = last_slot;
    cnt_n     = cnt;
    pending_n = pending;
    den_n     = 1'b0;
    daddr_n   = daddr;
    sout_n    = sample_out;
    sch_n     = sample_ch;
    sval_n    = 1'b0;
    tmo_n     = 1'b0;
    ovr_n     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (eoc && pending) ovr_n = 1'b1;
        if (eoc || pending) begin
          // With nothing enabled the trigger is consumed and forgotten.
          pending_n = 1'b0;
          if (ch_enable != '0) begin
            state_n = ISSUE;
            grant_n = rr_slot;
            den_n   = 1'b1;
            daddr_n = addr_arr[rr_slot];
          end
        end
      end
      ISSUE: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // drdy wins even on the final counted cycle.
        if (drdy) begin
          sout_n  = do_in;
          sch_n   = grant;
          sval_n  = 1'b1;
          state_n = CAPTURE;
        end else if (cnt == CNT_LAST) begin
          tmo_n   = 1'b1;
          last_n  = grant;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      CAPTURE: begin
        last_n  = grant;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // While busy one eoc is remembered; any more are dropped.
    if (state != IDLE && eoc) begin
      if (pending) ovr_n = 1'b1;
      else         pending_n = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= '0;
      last_slot    <= SLOT_TOP;
      cnt          <= '0;
      pending      <= 1'b0;
      den          <= 1'b0;
      daddr        <= '0;
      sample_out   <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      grant        <= grant_n;
      last_slot    <= last_n;
      cnt          <= cnt_n;
      pending      <= pending_n;
      den          <= den_n;
      daddr        <= daddr_n;
      sample_out   <= sout_n;
      sample_ch    <= sch_n;
      sample_valid <= sval_n;
      timeout_err  <= tmo_n;
      overrun      <= ovr_n;
    end
  end

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Bench for xadc_drp_scheduler: table of round-robin reads plus directed corner sequences.
// Inputs driven 1 ns after the rising edge; outputs sampled at the same point.
// Every check is against hand-computed values.
module tb_xadc_drp_scheduler;

  localparam logic [27:0] ADDRS = {7'h43, 7'h32, 7'h21, 7'h1F};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [27:0] ch_addr = ADDRS;
  logic [3:0]  ch_enable = 4'b0;
  logic        eoc = 1'b0;
  logic        den;
  logic [6:0]  daddr;
  logic        dwe;
  logic        drdy = 1'b0;
  logic [15:0] do_in = 16'h0;
  logic [15:0] sample_out;
  logic [2:0]  sample_ch;
  logic        sample_valid;
  logic        timeout_err;
  logic        overrun;
  logic        busy;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int den_seen = 0, sv_seen = 0, tmo_seen = 0, ovr_seen = 0;
  logic [15:0] last_data = 16'h0;

  xadc_drp_scheduler #(.NUM_CH(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .ch_addr(ch_addr), .ch_enable(ch_enable), .eoc(eoc),
    .den(den), .daddr(daddr), .dwe(dwe), .drdy(drdy), .do_in(do_in),
    .sample_out(sample_out), .sample_ch(sample_ch), .sample_valid(sample_valid),
    .timeout_err(timeout_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        rst;
    logic [3:0]  en;
    logic [15:0] data;
    int          dly;
    logic [6:0]  addr;
    logic [2:0]  ch;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (den)          den_seen++;
    if (sample_valid) sv_seen++;
    if (timeout_err)  tmo_seen++;
    if (overrun)      ovr_seen++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_den"}, den, 0);
    chk({tag, "_daddr"}, daddr, 0);
    chk({tag, "_dwe"}, dwe, 0);
    chk({tag, "_sample_out"}, sample_out, 0);
    chk({tag, "_sample_ch"}, sample_ch, 0);
    chk({tag, "_sample_valid"}, sample_valid, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // One complete read; ch_enable/ch_addr are scrambled during WAIT to show they are ignored.
  task automatic do_read(input logic [3:0] en, input logic [15:0] data, input int dly,
                         input logic [6:0] exp_addr, input logic [2:0] exp_ch);
    ch_enable = en;
    eoc = 1'b1;
    tick();
    eoc = 1'b0;
    chk("rd_den_issue", den, 1);
    chk("rd_daddr", daddr, exp_addr);
    chk("rd_busy", busy, 1);
    tick();
    chk("rd_den_single", den, 0);
    ch_enable = ~en;
    ch_addr = 28'h0;
    repeat (dly) tick();
    drdy = 1'b1;
    do_in = data;
    tick();
    drdy = 1'b0;
    do_in = 16'h0;
    chk("rd_sample_valid", sample_valid, 1);
    chk("rd_sample_out", sample_out, data);
    chk("rd_sample_ch", sample_ch, exp_ch);
    chk("rd_no_timeout", timeout_err, 0);
    chk("rd_daddr_hold", daddr, exp_addr);
    last_data = data;
    ch_addr = ADDRS;
    ch_enable = en;
    tick();
    chk("rd_sample_valid_end", sample_valid, 0);
    chk("rd_busy_end", busy, 0);
  endtask

  initial begin
    int b_den, b_sv, b_tmo, b_ovr;

    //           rst   en       data      dly addr   ch
    vecs[0]  = '{1'b0, 4'b0001, 16'hABC0, 2,  7'h1F, 3'd0};
    vecs[1]  = '{1'b1, 4'b1011, 16'h1111, 0,  7'h1F, 3'd0};
    vecs[2]  = '{1'b0, 4'b1011, 16'h2222, 1,  7'h21, 3'd1};
    vecs[3]  = '{1'b0, 4'b1011, 16'h3333, 3,  7'h43, 3'd3};
    vecs[4]  = '{1'b0, 4'b1011, 16'h4444, 0,  7'h1F, 3'd0};
    vecs[5]  = '{1'b0, 4'b1011, 16'h5555, 5,  7'h21, 3'd1};
    vecs[6]  = '{1'b0, 4'b0100, 16'h6666, 0,  7'h32, 3'd2};
    vecs[7]  = '{1'b0, 4'b0100, 16'h7777, 2,  7'h32, 3'd2};
    vecs[8]  = '{1'b0, 4'b1000, 16'h8888, 1,  7'h43, 3'd3};
    vecs[9]  = '{1'b0, 4'b1001, 16'h9999, 0,  7'h1F, 3'd0};
    vecs[10] = '{1'b0, 4'b0110, 16'hAAAA, 4,  7'h21, 3'd1};
    vecs[11] = '{1'b0, 4'b0110, 16'hBEEF, 63, 7'h32, 3'd2};

    reset_dut();
    // First read lines up with eoc at cycle 10, drdy at 14, sample_valid at 15.
    while (cyc < 10) tick();

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst) reset_dut();
      do_read(vecs[i].en, vecs[i].data, vecs[i].dly, vecs[i].addr, vecs[i].ch);
    end

    // Timeout: last slot 2, enable 0110 -> slot 1; no drdy ever comes.
    b_sv = sv_seen;
    b_tmo = tmo_seen;
    ch_enable = 4'b0110;
    eoc = 1'b1;
    tick();
    eoc = 1'b0;
    chk("to_den", den, 1);
    chk("to_daddr", daddr, 7'h21);
    repeat (64) tick();
    chk("to_no_early_pulse", tmo_seen - b_tmo, 0);
    tick();
    chk("to_timeout_err", timeout_err, 1);
    chk("to_busy_idle", busy, 0);
    chk("to_sample_kept", sample_out, last_data);
    chk("to_no_sample_valid", sv_seen - b_sv, 0);
    tick();
    chk("to_pulse_single", timeout_err, 0);
    do_read(4'b0110, 16'hC0DE, 1, 7'h32, 3'd2);

    // Overrun: read of slot 1, two more eocs during WAIT -> one overrun, one extra read.
    b_den = den_seen;
    b_ovr = ovr_seen;
    ch_enable = 4'b0110;
    eoc = 1'b1; tick(); eoc = 1'b0;
    tick();
    eoc = 1'b1; tick(); eoc = 1'b0;
    tick();
    eoc = 1'b1; tick(); eoc = 1'b0;
    tick();
    drdy = 1'b1; do_in = 16'h1234; tick(); drdy = 1'b0;
    chk("ov_first_valid", sample_valid, 1);
    chk("ov_first_ch", sample_ch, 1);
    tick();
    chk("ov_idle_no_den", den, 0);
    tick();
    chk("ov_pending_den", den, 1);
    chk("ov_pending_daddr", daddr, 7'h32);
    tick();
    drdy = 1'b1; do_in = 16'h5678; tick(); drdy = 1'b0;
    chk("ov_second_valid", sample_valid, 1);
    chk("ov_second_data", sample_out, 16'h5678);
    chk("ov_second_ch", sample_ch, 2);
    repeat (6) tick();
    chk("ov_overrun_count", ovr_seen - b_ovr, 1);
    chk("ov_den_count", den_seen - b_den, 2);

    // Reset in the middle of WAIT, then a stray drdy after release.
    ch_enable = 4'b0110;
    eoc = 1'b1; tick(); eoc = 1'b0;
    tick();
    tick();
    b_sv = sv_seen;
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    tick();
    reset = 1'b0;
    drdy = 1'b1; do_in = 16'hDEAD;
    tick();
    drdy = 1'b0; do_in = 16'h0;
    tick();
    chk("midrst_late_drdy_ignored", sv_seen - b_sv, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sample_out", sample_out, 0);
    do_read(4'b1111, 16'h0F0F, 0, 7'h1F, 3'd0);

    // Nothing enabled: eocs and a stray drdy produce no activity at all.
    b_den = den_seen;
    b_ovr = ovr_seen;
    b_sv = sv_seen;
    ch_enable = 4'b0000;
    eoc = 1'b1; tick(); eoc = 1'b0;
    chk("noen_busy", busy, 0);
    eoc = 1'b1; tick(); eoc = 1'b0;
    drdy = 1'b1; tick(); drdy = 1'b0;
    ch_enable = 4'b0001;
    repeat (4) tick();
    chk("noen_den_count", den_seen - b_den, 0);
    chk("noen_overrun_count", ovr_seen - b_ovr, 0);
    chk("noen_valid_count", sv_seen - b_sv, 0);
    chk("noen_busy_end", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
